// File: rtl/residue_hist4_if.sv
// residue_hist4_if: stream handshake plus histogram result bus for residue_hist4.
// The WINCNT member exists only when RESHIST_WINCNT_EN is defined.
interface residue_hist4_if #(
  parameter int CW = 5
);
  logic          IN_VALID;
  logic [3:0]    RES;
  logic          IN_READY;
  logic [CW-1:0] CNT0;
  logic [CW-1:0] CNT1;
  logic [CW-1:0] CNT2;
  logic [CW-1:0] CNT3;
  logic          DONE;
  logic          ERR;
`ifdef RESHIST_WINCNT_EN
  logic [7:0]    WINCNT;

  // Upstream producer / result consumer side.
  modport master (
    output IN_VALID, RES,
    input  IN_READY, CNT0, CNT1, CNT2, CNT3, DONE, ERR, WINCNT
  );

  // Histogram block side.
  modport slave (
    input  IN_VALID, RES,
    output IN_READY, CNT0, CNT1, CNT2, CNT3, DONE, ERR, WINCNT
  );
`else
  // Upstream producer / result consumer side.
  modport master (
    output IN_VALID, RES,
    input  IN_READY, CNT0, CNT1, CNT2, CNT3, DONE, ERR
  );

  // Histogram block side.
  modport slave (
    input  IN_VALID, RES,
    output IN_READY, CNT0, CNT1, CNT2, CNT3, DONE, ERR
  );
`endif
endinterface

// File: rtl/residue_hist4.sv
// residue_hist4: counts residues 0..3 over windows of WIN legal samples,
// publishes the four counts with a one-cycle DONE, and flags any accepted
// residue with nonzero upper bits via a sticky ERR.
// Optional: define RESHIST_WINCNT_EN to add an 8-bit completed-window counter.
module residue_hist4 #(
  parameter int WIN = 16,
  parameter int CW  = 5
) (
  input  logic           CLK,
  input  logic           RST,
  residue_hist4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] work     [4];
  logic [CW-1:0] work_nxt [4];
  logic [CW-1:0] pub      [4];
  logic [CW-1:0] sample_cnt;
  logic          err;
  logic          accept;
  logic          legal;
  logic          legal_accept;
  logic          last;

  // Handshake decode and the working histogram including this cycle's sample.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    accept       = bus.IN_VALID && (state != REPORT);
    legal        = (bus.RES[3:2] == 2'b00);
    legal_accept = accept && legal;
    last         = (sample_cnt == CW'(WIN - 1));
    for (int k = 0; k < 4; k++) begin
      work_nxt[k] = work[k];
      if (legal_accept && (bus.RES[1:0] == 2'(k))) begin
        work_nxt[k] = work[k] + CW'(1);
      end
    end
  end

  // Next-state: the WIN-th legal sample ends the window; REPORT is one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, COUNT: begin
        if (legal_accept) begin
          state_nxt = last ? REPORT : COUNT;
        end
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Working counters, sample counter, published counts and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: these small counter arrays are flops, not RAM, so they are reset explicitly.
      for (int k = 0; k < 4; k++) begin
        work[k] <= '0;
        pub[k]  <= '0;
      end
      sample_cnt <= '0;
      err        <= 1'b0;
    end else begin
      if (state == REPORT) begin
        for (int k = 0; k < 4; k++) begin
          work[k] <= '0;
        end
        sample_cnt <= '0;
      end else if (legal_accept) begin
        work       <= work_nxt;
        sample_cnt <= sample_cnt + CW'(1);
        if (last) begin
          pub <= work_nxt;
        end
      end
      if (accept && !legal) begin
        err <= 1'b1;
      end
    end
  end

`ifdef RESHIST_WINCNT_EN
  logic [7:0] wincnt;

  // Completed-window counter, wraps naturally at 8 bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wincnt <= 8'd0;
    end else if (state == REPORT) begin
      wincnt <= wincnt + 8'd1;
    end
  end

  assign bus.WINCNT = wincnt;
`endif

  assign bus.IN_READY = (state != REPORT);
  assign bus.DONE     = (state == REPORT);
  assign bus.CNT0     = pub[0];
  assign bus.CNT1     = pub[1];
  assign bus.CNT2     = pub[2];
  assign bus.CNT3     = pub[3];
  assign bus.ERR      = err;

endmodule

// File: tb/tb_residue_hist4.sv
// tb_residue_hist4: directed stimulus for residue_hist4 with a histogram
// reference model checked every cycle plus hand-computed literal checks.
// Build with RESHIST_WINCNT_EN defined to also check WINCNT.
module tb_residue_hist4;

  localparam int WIN = 16;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   started = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  residue_hist4_if #(.CW(CW)) bus ();

  residue_hist4 #(.WIN(WIN), .CW(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a histogram of legal accepted residues; a full window
  // publishes its histogram and blocks input for exactly one cycle.
  int m_hist [4];
  int m_pub  [4];
  int m_n;
  bit m_done;
  bit m_err;
  int m_wincnt;

  always @(posedge clk) begin
    if (rst) begin
      m_hist   = '{default: 0};
      m_pub    = '{default: 0};
      m_n      = 0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_wincnt = 0;
    end else if (m_done) begin
      m_done   = 1'b0;
      m_wincnt = (m_wincnt + 1) % 256;
    end else if (bus.IN_VALID) begin
      if (bus.RES[3:2] != 2'b00) begin
        m_err = 1'b1;
      end else begin
        m_hist[bus.RES[1:0]]++;
        m_n++;
        if (m_n == WIN) begin
          m_pub  = m_hist;
          m_hist = '{default: 0};
          m_n    = 0;
          m_done = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model mid-cycle, every cycle after reset.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", 32'(bus.IN_READY), 32'(!m_done));
      check("done",     32'(bus.DONE),     32'(m_done));
      check("err",      32'(bus.ERR),      32'(m_err));
      check("cnt0",     32'(bus.CNT0),     32'(m_pub[0]));
      check("cnt1",     32'(bus.CNT1),     32'(m_pub[1]));
      check("cnt2",     32'(bus.CNT2),     32'(m_pub[2]));
      check("cnt3",     32'(bus.CNT3),     32'(m_pub[3]));
`ifdef RESHIST_WINCNT_EN
      check("wincnt",   32'(bus.WINCNT),   32'(m_wincnt));
`endif
      if (bus.DONE === 1'b1) begin
        check("cnt_sum", 32'(bus.CNT0) + 32'(bus.CNT1) + 32'(bus.CNT2) + 32'(bus.CNT3), WIN);
      end
    end
  end

  // Offer one sample and hold it until accepted; IN_VALID stays high on return.
  task automatic send(input logic [3:0] r);
    logic rdy;
    int   guard;
    bus.IN_VALID = 1'b1;
    bus.RES      = r;
    guard        = 0;
    do begin
      rdy = bus.IN_READY;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 20);
    if (!rdy) check("send_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.IN_VALID = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counts(input string tag, input int c0, input int c1, input int c2, input int c3);
    check({tag, "_cnt0"}, 32'(bus.CNT0), c0);
    check({tag, "_cnt1"}, 32'(bus.CNT1), c1);
    check({tag, "_cnt2"}, 32'(bus.CNT2), c2);
    check({tag, "_cnt3"}, 32'(bus.CNT3), c3);
  endtask

  task automatic pulse_reset();
    bus.IN_VALID = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.IN_VALID = 1'b0;
    bus.RES      = 4'd0;
    @(posedge clk);
    #1;
    started = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(bus.IN_READY), 32'd1);
    check("rst_done",  32'(bus.DONE),     32'd0);
    check("rst_err",   32'(bus.ERR),      32'd0);
    check_counts("rst", 0, 0, 0, 0);

    // Back-to-back 0,1,2,3 pattern.
    for (int i = 0; i < 16; i++) send(4'(i % 4));
    check("t1_done",  32'(bus.DONE),     32'd1);
    check("t1_ready", 32'(bus.IN_READY), 32'd0);
    check("t1_err",   32'(bus.ERR),      32'd0);
    check_counts("t1", 4, 4, 4, 4);

    // All 3s, then all 0s.
    for (int i = 0; i < 16; i++) send(4'd3);
    check_counts("t2a", 0, 0, 0, 16);
    for (int i = 0; i < 16; i++) send(4'd0);
    check("t2b_done", 32'(bus.DONE), 32'd1);
    check_counts("t2b", 16, 0, 0, 0);

    // 0,0,1,2 pattern with random idle gaps.
    idle(1);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] pat [4];
      pat = '{4'd0, 4'd0, 4'd1, 4'd2};
      idle($urandom_range(0, 2));
      send(pat[i % 4]);
    end
    check("t3_done", 32'(bus.DONE), 32'd1);
    check_counts("t3", 8, 4, 4, 0);

    // 17 accepts, the fifth one illegal.
    for (int i = 0; i < 17; i++) begin
      if (i == 4) begin
        send(4'b0101);
        check("t4_err_set", 32'(bus.ERR), 32'd1);
      end else begin
        send(4'(i % 4));
      end
    end
    check("t4_done", 32'(bus.DONE), 32'd1);
    check_counts("t4", 4, 4, 4, 4);
    for (int i = 0; i < 16; i++) send(4'd1);
    check_counts("t4b", 0, 16, 0, 0);
    check("t4_err_sticky", 32'(bus.ERR), 32'd1);

    // Reset mid-window after 10 accepts, then a fresh window.
    idle(1);
    for (int i = 0; i < 10; i++) send(4'd2);
    pulse_reset();
    check("t5_ready", 32'(bus.IN_READY), 32'd1);
    check("t5_done",  32'(bus.DONE),     32'd0);
    check("t5_err",   32'(bus.ERR),      32'd0);
    check_counts("t5_rst", 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) send((i < 8) ? 4'd1 : 4'd3);
    check_counts("t5", 0, 8, 0, 8);

    // RES=2 held valid through REPORT carries into the next window.
    pulse_reset();
`ifdef RESHIST_WINCNT_EN
    check("t6_wincnt0", 32'(bus.WINCNT), 32'd0);
`endif
    for (int i = 0; i < 15; i++) send(4'd1);
    send(4'd2);
    check("t6_done1",  32'(bus.DONE),     32'd1);
    check("t6_ready1", 32'(bus.IN_READY), 32'd0);
    check_counts("t6a", 0, 15, 1, 0);
    send(4'd2);
    check("t6_no_done", 32'(bus.DONE), 32'd0);
`ifdef RESHIST_WINCNT_EN
    check("t6_wincnt1", 32'(bus.WINCNT), 32'd1);
`endif
    for (int i = 0; i < 15; i++) send(4'd0);
    check("t6_done2", 32'(bus.DONE), 32'd1);
    check_counts("t6b", 15, 0, 1, 0);
    idle(1);
`ifdef RESHIST_WINCNT_EN
    check("t6_wincnt2", 32'(bus.WINCNT), 32'd2);
`endif
    check("t6_hold_cnt0", 32'(bus.CNT0), 32'd15);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/residue_hist4.md
Name: residue_hist4

Overview:
- Downstream consumer of the 4-bit modulo-4 residue stage.
- Accepts a stream of residues over a valid/ready handshake and counts how often each residue 0..3 occurs in a fixed-length window of WIN accepted samples.
- At window end it publishes the four counts, pulses DONE, and starts the next window.
- Flags malformed residues, i.e. inputs with RES[3:2] not zero.

Parameters:
- WIN, 16, samples per window; must satisfy 1 <= WIN < 2^CW.
- CW, 5, width of each count output and of the internal sample counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  RES holds a sample this cycle.
- RES  input  4  residue from the mod-4 stage; only values 0..3 are legal.
- IN_READY  output  1  block can accept a sample this cycle.
- CNT0  output  CW  occurrences of residue 0 in the last completed window.
- CNT1  output  CW  occurrences of residue 1 in the last completed window.
- CNT2  output  CW  occurrences of residue 2 in the last completed window.
- CNT3  output  CW  occurrences of residue 3 in the last completed window.
- DONE  output  1  one-cycle pulse when CNT0..CNT3 update.
- ERR  output  1  sticky flag: an illegal residue was accepted.

Behaviour:
- Interface: one clock CLK. RST is synchronous and active-high, sampled on the CLK rising edge.
- Reset values: state IDLE, IN_READY=1, CNT0..CNT3=0, DONE=0, ERR=0, working counters and sample counter 0.
- Reset mid-window discards the partial window. Published counts are also cleared.
- Accept happens when IN_VALID & IN_READY. With IN_VALID low, no internal state changes.
- Legal accept (RES[3:2]==0):
  - working counter RES[1:0] increments;
  - sample counter increments.
- Illegal accept (RES[3:2]!=0):
  - handshake completes, but the sample is dropped;
  - no working counter and no sample counter change;
  - ERR goes to 1 the next cycle and stays 1 until RST.
- States:
  - IDLE: IN_READY=1. The first legal accept moves to COUNT, or to REPORT if WIN==1.
  - COUNT: IN_READY=1. The legal accept that brings the sample counter to WIN moves to REPORT. Otherwise stay.
  - REPORT: lasts exactly one cycle.
    - IN_READY=0 and DONE=1.
    - CNT0..CNT3 show the finished window.
    - Working counters and sample counter clear.
    - Next state is IDLE.
- Latency: DONE and the new CNTx appear in the cycle after the WIN-th legal accept. CNTx hold until the next DONE.
- Invariant: CNT0+CNT1+CNT2+CNT3 == WIN at every DONE.
- Samples offered during REPORT are not accepted. The upstream must hold them; they count toward the next window.
- Working counters never exceed WIN, so there is no wrap or saturation logic.

Optional Feature:
- Macro: RESHIST_WINCNT_EN.
- Defined:
  - adds output port WINCNT, output, 8 bits: number of completed windows;
  - resets to 0 and increments in every REPORT cycle;
  - wraps 255 -> 0.
- Not defined:
  - port and logic absent;
  - all other behaviour identical.

Test Plan:
- RST, then 16 back-to-back legal samples 0,1,2,3 repeated -> DONE high exactly one cycle after the 16th accept; CNT0..CNT3 = 4,4,4,4; IN_READY=0 in that cycle; ERR=0.
- 16 samples all RES=3 -> CNT3=16, CNT0..CNT2=0. In a second window of 16 samples all RES=0, the second DONE shows CNT0=16, CNT3=0.
- 16 legal samples (pattern 0,0,1,2 repeated) spread over 40 cycles with random IN_VALID gaps -> no DONE before the 16th accept; CNT0..CNT3 = 8,4,4,0.
- 17 accepts with the 5th being RES=4'b0101 -> ERR=1 from the following cycle onward; DONE after the 17th accept; count sum = 16; ERR still 1 after the next window.
- RST asserted after 10 accepts -> next cycle CNT0..CNT3=0, DONE=0, ERR=0, IN_READY=1. A fresh 16-sample window then reports correct counts only.
- IN_VALID held high with RES=2 through the REPORT cycle -> that sample is not accepted in REPORT; it is accepted the following cycle and appears in the next window's CNT2. With RESHIST_WINCNT_EN defined, WINCNT goes 0 -> 1 -> 2 across the two DONE pulses.
